// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner back end.
// The debounce state encoding and the anode patterns live here.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } debounce_state_t;

    localparam logic [1:0] AN_NEW = 2'b10;
    localparam logic [1:0] AN_OLD = 2'b01;

endpackage

// File: rtl/key_history_mux_if.sv
// Scanner-side link: decoded key and strobe in, history feedback and accept pulse out.
interface key_history_mux_if;

    logic [3:0] key_code;
    logic       key_strobe;
    logic [3:0] prev_num;
    logic       key_accept;

    modport master (
        output key_code,
        output key_strobe,
        input  prev_num,
        input  key_accept
    );

    modport slave (
        input  key_code,
        input  key_strobe,
        output prev_num,
        output key_accept
    );

endinterface

// File: rtl/digit_mux.sv
// Alternates the two history digits onto the shared seven-segment decoder.
// Outputs are decoded combinationally from a registered select, so they never glitch.
module digit_mux
    import keypad_pkg::*;
#(
    parameter int MUX_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] digit_new,
    input  logic [3:0] digit_old,
    output logic [3:0] seg_digit,
    output logic [1:0] an_n
);

    localparam int MW = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;
    localparam logic [MW-1:0] MCNT_LAST = MW'(MUX_CYCLES - 1);

    logic [MW-1:0] r_mcnt;
    logic          r_sel;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_mcnt <= '0;
            r_sel  <= 1'b0;
        end else if (r_mcnt == MCNT_LAST) begin
            r_mcnt <= '0;
            r_sel  <= ~r_sel;
        end else begin
            r_mcnt <= r_mcnt + MW'(1);
        end
    end

    always_comb begin
        an_n      = AN_NEW;
        seg_digit = digit_new;
        if (r_sel) begin
            an_n      = AN_OLD;
            seg_digit = digit_old;
        end
    end

endmodule

// File: rtl/key_history_mux.sv
// Debounces scanner key presses/releases, keeps a two-digit history and
// drives the multiplexed display of that history.
module key_history_mux
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int MUX_CYCLES      = 24000
) (
    input  logic              clk,
    input  logic              nrst,
    key_history_mux_if.slave  bus,
    output logic [3:0]        digit_new,
    output logic [3:0]        digit_old,
    output logic [3:0]        seg_digit,
    output logic [1:0]        an_n
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    debounce_state_t r_state, w_stateNext;
    logic [CW-1:0]   r_cnt, w_cntNext;
    logic [3:0]      r_cand, w_candNext;
    logic [3:0]      r_digitNew, w_digitNewNext;
    logic [3:0]      r_digitOld, w_digitOldNext;
    logic            r_accept, w_acceptNext;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cand     <= '0;
            r_digitNew <= '0;
            r_digitOld <= '0;
            r_accept   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_cand     <= w_candNext;
            r_digitNew <= w_digitNewNext;
            r_digitOld <= w_digitOldNext;
            r_accept   <= w_acceptNext;
        end
    end

    // Repeated presses of one key are distinguished only by the release debounce.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_candNext     = r_cand;
        w_digitNewNext = r_digitNew;
        w_digitOldNext = r_digitOld;
        w_acceptNext   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.key_strobe) begin
                    w_candNext  = bus.key_code;
                    w_cntNext   = '0;
                    w_stateNext = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!bus.key_strobe || (bus.key_code != r_cand)) begin
                    w_stateNext = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_digitOldNext = r_digitNew;
                    w_digitNewNext = r_cand;
                    w_acceptNext   = 1'b1;
                    w_stateNext    = HELD;
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!bus.key_strobe) begin
                    w_cntNext   = '0;
                    w_stateNext = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (bus.key_strobe) begin
                    w_stateNext = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE;
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign bus.prev_num   = r_digitNew;
    assign bus.key_accept = r_accept;
    assign digit_new      = r_digitNew;
    assign digit_old      = r_digitOld;

    digit_mux #(
        .MUX_CYCLES (MUX_CYCLES)
    ) u_digit_mux (
        .clk       (clk),
        .nrst      (nrst),
        .digit_new (r_digitNew),
        .digit_old (r_digitOld),
        .seg_digit (seg_digit),
        .an_n      (an_n)
    );

endmodule

// File: tb/tb_key_history_mux.sv
// Scoreboard bench for key_history_mux with short debounce and mux periods.
// Expected accepts are queued at stimulus time and popped by a separate monitor.
module tb_key_history_mux;
    import keypad_pkg::*;

    localparam int DEB = 4;
    localparam int MUX = 3;

    typedef struct {
        logic [3:0] expNew;
        logic [3:0] expOld;
        int         expCyc;
    } accept_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] digit_new, digit_old, seg_digit;
    logic [1:0] an_n;

    key_history_mux_if bus ();

    key_history_mux #(
        .DEBOUNCE_CYCLES (DEB),
        .MUX_CYCLES      (MUX)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .bus       (bus),
        .digit_new (digit_new),
        .digit_old (digit_old),
        .seg_digit (seg_digit),
        .an_n      (an_n)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         assertCount = 0;
    int         failCount = 0;
    accept_t    sb[$];
    logic [3:0] modelNew = 4'h0;
    logic [3:0] modelOld = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every accept pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        accept_t e;
        if (nrst === 1'b1) begin
            checkOutput("an_n_legal", {31'd0, (an_n == AN_NEW) || (an_n == AN_OLD)}, 32'd1);
            if (bus.key_accept === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("accept_cycle", e.expCyc, cyc);
                    checkOutput("accept_digit_new", {28'd0, digit_new}, {28'd0, e.expNew});
                    checkOutput("accept_digit_old", {28'd0, digit_old}, {28'd0, e.expOld});
                    checkOutput("accept_prev_num", {28'd0, bus.prev_num}, {28'd0, e.expNew});
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] c, input int n);
        bus.key_strobe = s;
        bus.key_code   = c;
        waitCycles(n);
    endtask

    task automatic pressKey(input logic [3:0] c, input int hold);
        accept_t e;
        modelOld   = modelNew;
        modelNew   = c;
        e.expNew   = modelNew;
        e.expOld   = modelOld;
        e.expCyc   = cyc + DEB;
        sb.push_back(e);
        applyStimulus(1'b1, c, hold);
    endtask

    task automatic checkHistory(input string tag);
        @(negedge clk);
        checkOutput({tag, "_digit_new"}, {28'd0, digit_new}, {28'd0, modelNew});
        checkOutput({tag, "_digit_old"}, {28'd0, digit_old}, {28'd0, modelOld});
        checkOutput({tag, "_prev_num"}, {28'd0, bus.prev_num}, {28'd0, modelNew});
        waitCycles(1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_digit_new"}, {28'd0, digit_new}, 32'd0);
        checkOutput({tag, "_digit_old"}, {28'd0, digit_old}, 32'd0);
        checkOutput({tag, "_prev_num"}, {28'd0, bus.prev_num}, 32'd0);
        checkOutput({tag, "_key_accept"}, {31'd0, bus.key_accept}, 32'd0);
        checkOutput({tag, "_an_n"}, {30'd0, an_n}, 32'h2);
        checkOutput({tag, "_seg_digit"}, {28'd0, seg_digit}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nrst           = 1'b0;
        bus.key_strobe = 1'b0;
        bus.key_code   = 4'h0;
        waitCycles(2);
        @(negedge clk);
        checkResetState("reset");

        // Mux sequence after release: select toggles every MUX edges.
        waitCycles(1);
        nrst = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checkOutput("mux_an_n", {30'd0, an_n}, ((n / MUX) % 2 == 1) ? 32'h1 : 32'h2);
            checkOutput("mux_seg_digit", {28'd0, seg_digit}, 32'd0);
        end
        waitCycles(1);

        pressKey(4'h5, 10);
        applyStimulus(1'b0, 4'h0, 6);
        checkHistory("first5");

        pressKey(4'h5, 10);
        applyStimulus(1'b0, 4'h0, 6);
        checkHistory("second5");

        applyStimulus(1'b1, 4'h9, 3);
        applyStimulus(1'b0, 4'h9, 3);
        checkHistory("short_press");

        applyStimulus(1'b1, 4'h3, 2);
        applyStimulus(1'b1, 4'h7, 2);
        applyStimulus(1'b0, 4'h7, 3);
        checkHistory("code_change");

        pressKey(4'hA, 8);
        applyStimulus(1'b0, 4'h2, 1);
        applyStimulus(1'b1, 4'h2, 6);
        applyStimulus(1'b0, 4'h2, 6);
        checkHistory("held_glitch");

        // With history A/5, whichever anode is active must carry its own digit.
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (an_n == AN_NEW)
                checkOutput("mux_new_digit", {28'd0, seg_digit}, 32'hA);
            else
                checkOutput("mux_old_digit", {28'd0, seg_digit}, 32'h5);
        end
        waitCycles(1);

        applyStimulus(1'b1, 4'h3, 2);
        nrst           = 1'b0;
        bus.key_strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetState("midreset");
        nrst     = 1'b1;
        modelNew = 4'h0;
        modelOld = 4'h0;
        waitCycles(1);

        pressKey(4'hC, 8);
        applyStimulus(1'b0, 4'h0, 6);
        checkHistory("after_reset_C");

        waitCycles(3);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/key_history_mux.md
# key_history_mux

Downstream stage of the keypad scanner. Accepts the scanner's decoded key code and a "key detected" level, and debounces both press and release. Each accepted key is shifted into a two-digit history (newest, previous), and the history is fed back to the scanner as its hold value. The block also time-multiplexes the two digits onto the shared seven-segment decoder with active-low anode selects.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release; minimum 2.
- MUX_CYCLES, 24000: cycles each digit is displayed before the anode select toggles; minimum 2.

Ports:
- clk  in  1  system clock; the only clock.
- nrst  in  1  synchronous, active-low reset, sampled on posedge clk.
- key_code  in  4  hex code of the detected key, from the scanner.
- key_strobe  in  1  high while the scanner reports exactly one key pressed.
- prev_num  out  4  newest accepted digit, fed back to the scanner; equals digit_new.
- digit_new  out  4  most recently accepted key.
- digit_old  out  4  key accepted before digit_new.
- key_accept  out  1  one-cycle pulse in the cycle the history updates.
- seg_digit  out  4  digit currently routed to the seven-segment decoder.
- an_n  out  2  active-low anode selects; an_n[0] is the new digit, an_n[1] is the old digit.

## Operation
Debounce FSM, with states IDLE, DEB_PRESS, HELD and DEB_RELEASE; one counter cnt, width $clog2(DEBOUNCE_CYCLES).
- IDLE: if key_strobe=1, capture cand<=key_code, set cnt<=0 and go to DEB_PRESS. Otherwise stay.
- DEB_PRESS:
  - If key_strobe=0 or key_code!=cand, go to IDLE; the candidate is discarded and the history is unchanged.
  - Else if cnt==DEBOUNCE_CYCLES-2: set digit_old<=digit_new, digit_new<=cand, key_accept<=1, and go to HELD.
  - Else cnt<=cnt+1.
- HELD: stay while key_strobe=1. Changes of key_code are ignored; there is no rollover. On key_strobe=0, set cnt<=0 and go to DEB_RELEASE.
- DEB_RELEASE:
  - If key_strobe=1, return to HELD; the same press continues and no new accept occurs.
  - Else if cnt==DEBOUNCE_CYCLES-2, go to IDLE.
  - Else cnt<=cnt+1.
- key_accept is registered. It is high for exactly one cycle per accepted press and is 0 in every other cycle.
- Pressing the same key twice produces two accepts, giving digit_new==digit_old. Detection relies on the release debounce, not on comparing values.

Display mux:
- Free-running counter mcnt runs from 0 to MUX_CYCLES-1 and wraps to 0. On each wrap, the select bit sel toggles.
- sel=0: an_n=2'b10, seg_digit=digit_new.
- sel=1: an_n=2'b01, seg_digit=digit_old.
- an_n is never 2'b00 or 2'b11 outside reset.
- seg_digit and an_n are combinational from the registered sel and the digit registers, so they change glitch-free in the same cycle.
- The mux runs independently of the FSM. A history update is visible on seg_digit immediately if the affected digit is currently selected.

## Timing
- Reset values:
  - state=IDLE, cnt=0, cand=0.
  - digit_new=0, digit_old=0, prev_num=0.
  - key_accept=0.
  - mcnt=0, sel=0, so an_n=2'b10 and seg_digit=0.
- Reset mid-operation: the next edge with nrst=0 forces all of the above. A pending candidate is lost and the history is cleared.
- Press latency:
  - key_strobe is first sampled high at edge k; the FSM enters DEB_PRESS at edge k.
  - If the key stays stable, edge k+DEBOUNCE_CYCLES-1 updates the history and raises key_accept.
  - key_accept falls at edge k+DEBOUNCE_CYCLES.
  - Total: DEBOUNCE_CYCLES consecutive high samples, counting the sample taken at edge k.
- Release: DEBOUNCE_CYCLES consecutive low samples return the FSM to IDLE. The next press can be captured at the following edge.
- A one-cycle low glitch while in HELD costs nothing: the FSM goes HELD→DEB_RELEASE→HELD.
- Mux period: each digit is shown for exactly MUX_CYCLES cycles. The first toggle occurs at edge MUX_CYCLES after reset release.

## Structure
- Shared package keypad_pkg holds the debounce state enum (debounce_state_t, 2-bit) and the anode pattern constants AN_NEW=2'b10 and AN_OLD=2'b01.
- One sub-module, digit_mux, holds mcnt, sel and the seg_digit/an_n selection. Parameter: MUX_CYCLES. Inputs: clk, nrst, digit_new, digit_old.
- The FSM and history registers live in the top module.

## Test plan
Run the bench with DEBOUNCE_CYCLES=4 and MUX_CYCLES=3.
- Reset, then hold key_strobe=0 -> digit_new=0, digit_old=0, key_accept stays 0, an_n alternates 10/01 every 3 cycles.
- Hold key_code=5 with key_strobe=1 for 10 cycles, then 0 -> exactly one key_accept pulse, 4 cycles after strobe rises. Result: digit_new=5, digit_old=0, prev_num=5.
- Accept 5, release for 4 cycles, then press 5 again -> a second pulse, digit_new=5, digit_old=5.
- Strobe high for 3 cycles, then low -> no accept and the history is unchanged. Strobe high with key_code changing 3→7 mid-debounce -> no accept.
- While in HELD with digit_new=0xA, drop strobe for 1 cycle and change key_code to 2 -> no new accept; digit_new stays 0xA.
- Assert nrst=0 for one cycle during DEB_PRESS after history A/5 -> all outputs at reset values at the next edge. The subsequent stable press of 0xC is then accepted normally.
